// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer.
// One memory port is shared between instruction fetch and load/store.
// The block also owns the memory handshake, a wait-cycle watchdog, the
// retired-instruction counter and a sticky illegal-opcode/timeout trap.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic             trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The trap fires on the last not-ready cycle, i.e. when the count would reach TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               fetch_pend_q, fetch_pend_d;
  logic               illegal_q, illegal_d;
  logic               cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               fetch_req;
  logic               mem_req_int;
  logic               timeout_hit;
  logic               retire;

  // Request qualification: once a fetch request is raised it is held until ready.
  always_comb begin
    fetch_req   = run | fetch_pend_q;
    mem_req_int = ((state_q == S_FETCH) && fetch_req) ||
                  (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout_hit = (TIMEOUT != 0) && mem_req_int && !mem_ready && (wait_q == WAIT_LIMIT);
  end

  // Next-state, watchdog, trap and retire bookkeeping.
  always_comb begin
    state_d      = state_q;
    fetch_pend_d = 1'b0;
    illegal_d    = illegal_q;
    cause_d      = cause_q;
    retire       = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (fetch_req) begin
          if (mem_ready) begin
            state_d = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_TRAP;
          end else begin
            fetch_pend_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
      illegal_d = 1'b1;
      cause_d   = timeout_hit;
    end

    // Any state change is an entry into a fresh wait window.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_req_int && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      wait_q       <= '0;
      fetch_pend_q <= 1'b0;
      illegal_q    <= 1'b0;
      cause_q      <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      fetch_pend_q <= fetch_pend_d;
      illegal_q    <= illegal_d;
      cause_q      <= cause_d;
      instret_q    <= instret_d;
    end
  end

  // Control outputs decoded from the current state; forced low while in reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 3'b000;
    alu_op     = 2'b00;
    result_src = 2'b00;

    if (rst_n) begin
      mem_req = mem_req_int;
      case (state_q)
        S_FETCH: begin
          if (fetch_req && mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            alu_op     = 2'b00;
            result_src = 2'b10;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 3'b010;
          alu_op    = 2'b00;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b00;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = 3'b000;
          alu_op    = 2'b10;
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b00;
          imm_src   = (opcode == OP_LOAD) ? 3'b000 : 3'b001;
        end
        S_MEM_RD: begin
          addr_sel = 1'b1;
        end
        S_MEM_WR: begin
          addr_sel = 1'b1;
          mem_we   = 1'b1;
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          result_src = 2'b00;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
        end
        S_BRANCH: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b00;
          alu_op     = 2'b01;
          result_src = 2'b00;
          case (funct3)
            3'b000:  pc_write = zero;
            3'b001:  pc_write = !zero;
            default: pc_write = 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign illegal    = illegal_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule
